// File: rtl/led_mode_ctrl_pkg.sv
// led_mode_ctrl_pkg: shared constants for the LED mode controller.
//   - mode encodings (3-bit), speed limit
//   - pattern ROMs, packed with step 0 in the least significant nibble
//   - helpers for mode advance and per-mode step index wrap
package led_mode_ctrl_pkg;

  localparam logic [2:0] S_OFF     = 3'd0;
  localparam logic [2:0] S_BAR     = 3'd1;
  localparam logic [2:0] S_CHASE   = 3'd2;
  localparam logic [2:0] S_BLINK   = 3'd3;
  localparam logic [2:0] S_BREATHE = 3'd4;

  localparam logic [1:0] SPEED_MAX = 2'd3;

  localparam logic [31:0] BAR_ROM   = {4'b0000, 4'b0001, 4'b0011, 4'b0111,
                                       4'b1111, 4'b0111, 4'b0011, 4'b0001};
  localparam logic [15:0] CHASE_ROM = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
  localparam logic [7:0]  BLINK_ROM = {4'b0000, 4'b1111};

  function automatic logic [2:0] next_mode(input logic [2:0] m);
    case (m)
      S_OFF:   return S_BAR;
      S_BAR:   return S_CHASE;
      S_CHASE: return S_BLINK;
      S_BLINK: return S_BREATHE;
      default: return S_OFF;
    endcase
  endfunction

  function automatic logic [2:0] next_idx(input logic [2:0] m, input logic [2:0] idx);
    case (m)
      S_BAR:   return idx + 3'd1;
      S_CHASE: return {1'b0, idx[1:0] + 2'd1};
      S_BLINK: return {2'b00, ~idx[0]};
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/led_mode_ctrl_if.sv
// led_mode_ctrl_if: board-side pin bundle of the LED mode controller.
//   KEY[3:0] : raw pushbuttons, active-low (driven by the board / master)
//   LED[3:0] : LED drive, 1 = on (driven by the controller / slave)
interface led_mode_ctrl_if;
  logic [3:0] KEY;
  logic [3:0] LED;

  modport master (output KEY, input LED);
  modport slave  (input KEY, output LED);
endinterface

// File: rtl/led_mode_ctrl_key_debounce.sv
// key_debounce: 2-flop synchroniser, debounce and press detector for one key.
//   clk, rst : clock, synchronous active-high reset
//   key_raw  : asynchronous active-low button
//   press    : one-cycle pulse on a debounced 1->0 transition
module key_debounce #(
  parameter logic [19:0] DEB_CYCLES = 20'd1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic press
);

  logic        sync1, sync2;
  logic        deb;
  logic        armed;
  logic [19:0] cnt;

  // The synchroniser resets low and presses need 'armed', which is only set
  // once the synchronised key has been seen high: a key held through reset
  // must be released before it can press again.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b1;
      armed <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2) armed <= 1'b1;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == DEB_CYCLES - 20'd1) begin
        deb   <= sync2;
        cnt   <= '0;
        press <= armed & ~sync2;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

endmodule

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: 4-key LED pattern sequencer.
//   FPGA_CLK : system clock
//   RST      : synchronous active-high reset
//   io       : KEY[3:0] in (active-low buttons), LED[3:0] out (registered)
// KEY0 next mode, KEY1 run/pause, KEY2 speed+, KEY3 speed-; fixed priority,
// KEY0 highest, one command per cycle. Patterns step off a prescaler whose
// period is STEP_DIV >> speed.
module led_mode_ctrl
  import led_mode_ctrl_pkg::*;
#(
  parameter logic [24:0] STEP_DIV   = 25'd25000000,
  parameter logic [19:0] DEB_CYCLES = 20'd1000000
) (
  input  logic     FPGA_CLK,
  input  logic     RST,
  led_mode_ctrl_if.slave io
);

  logic [3:0]  press;
  logic        cmd_next, cmd_run, cmd_up, cmd_dn;

  logic [2:0]  mode;
  logic        run;
  logic [1:0]  speed;
  logic [24:0] step_cnt, sub_cnt;
  logic [2:0]  idx;
  logic [4:0]  level;
  logic        dir_up;
  logic [7:0]  pwm;
  logic [3:0]  led;

  logic [24:0] step_per, sub_per_raw, sub_per;
  logic        tick, sub_tick;
  logic [4:0]  level_nx;
  logic        dir_nx;
  logic [3:0]  led_nx;

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk     (FPGA_CLK),
      .rst     (RST),
      .key_raw (io.KEY[g]),
      .press   (press[g])
    );
  end

  assign cmd_next = press[0];
  assign cmd_run  = press[1] & ~press[0];
  assign cmd_up   = press[2] & ~|press[1:0];
  assign cmd_dn   = press[3] & ~|press[2:0];

  // Breathe sub-period is clamped to 1 so very short step periods still ramp.
  assign step_per    = STEP_DIV >> speed;
  assign sub_per_raw = step_per >> 5;
  assign sub_per     = (sub_per_raw == '0) ? 25'd1 : sub_per_raw;
  assign tick        = (step_cnt == step_per - 25'd1);
  assign sub_tick    = (sub_cnt == sub_per - 25'd1);

  always_comb begin
    level_nx = level;
    dir_nx   = dir_up;
    if (dir_up) begin
      if (level == 5'd31) begin
        level_nx = 5'd30;
        dir_nx   = 1'b0;
      end else begin
        level_nx = level + 5'd1;
      end
    end else begin
      if (level == '0) begin
        level_nx = 5'd1;
        dir_nx   = 1'b1;
      end else begin
        level_nx = level - 5'd1;
      end
    end
  end

  always_comb begin
    led_nx = '0;
    case (mode)
      S_BAR:     led_nx = BAR_ROM[{idx, 2'b00} +: 4];
      S_CHASE:   led_nx = CHASE_ROM[{idx[1:0], 2'b00} +: 4];
      S_BLINK:   led_nx = BLINK_ROM[{idx[0], 2'b00} +: 4];
      S_BREATHE: led_nx = {4{pwm[7:3] < level}};
      default:   led_nx = '0;
    endcase
  end

  // A command shadows a same-cycle tick: mode change and pause drop it, a
  // speed change applies it and then clears the counters.
  always_ff @(posedge FPGA_CLK) begin
    if (RST) begin
      mode     <= S_OFF;
      run      <= 1'b1;
      speed    <= '0;
      step_cnt <= '0;
      sub_cnt  <= '0;
      idx      <= '0;
      level    <= '0;
      dir_up   <= 1'b1;
      pwm      <= '0;
      led      <= '0;
    end else begin
      pwm <= pwm + 8'd1;
      led <= led_nx;
      if (cmd_next) begin
        mode     <= next_mode(mode);
        step_cnt <= '0;
        sub_cnt  <= '0;
        idx      <= '0;
        level    <= '0;
        dir_up   <= 1'b1;
      end else if (cmd_run) begin
        run <= ~run;
      end else begin
        if (cmd_up && speed != SPEED_MAX) speed <= speed + 2'd1;
        if (cmd_dn && speed != 2'd0)      speed <= speed - 2'd1;
        if (run) begin
          step_cnt <= tick ? '0 : step_cnt + 25'd1;
          sub_cnt  <= sub_tick ? '0 : sub_cnt + 25'd1;
          if (tick) idx <= next_idx(mode, idx);
          if (sub_tick && mode == S_BREATHE) begin
            level  <= level_nx;
            dir_up <= dir_nx;
          end
        end
        if (cmd_up || cmd_dn) begin
          step_cnt <= '0;
          sub_cnt  <= '0;
        end
      end
    end
  end

  assign io.LED = led;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl: self-checking bench for led_mode_ctrl with STEP_DIV=64,
// DEB_CYCLES=4. Expected LED values come from arithmetic pattern rules.
module tb_led_mode_ctrl;

  localparam int DEB = 4;
  localparam int SD  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] pwm_m;
  int tests = 0;
  int fails = 0;

  led_mode_ctrl_if bus ();

  led_mode_ctrl #(.STEP_DIV(25'd64), .DEB_CYCLES(20'd4)) dut (
    .FPGA_CLK (clk),
    .RST      (rst),
    .io       (bus)
  );

  always #5 clk = ~clk;

  // Reference free-running PWM counter value (cleared by reset).
  always @(posedge clk) pwm_m <= rst ? 8'd0 : pwm_m + 8'd1;

  function automatic logic [3:0] bar_led(input int i);
    int k, h;
    k = i % 8;
    h = (k < 4) ? k + 1 : 7 - k;
    return 4'((1 << h) - 1);
  endfunction

  function automatic logic [3:0] chase_led(input int i);
    return 4'(1 << (i % 4));
  endfunction

  function automatic int tri_lvl(input int p);
    int q;
    q = p % 62;
    return (q <= 31) ? q : 62 - q;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] mask, output logic [3:0] pre, output logic [3:0] post);
    repeat (DEB + 4) @(posedge clk);
    #1 bus.KEY = ~mask;
    repeat (DEB + 3) @(posedge clk);
    @(negedge clk); pre = bus.LED;
    @(posedge clk); #1 bus.KEY = 4'hF;
    @(negedge clk); post = bus.LED;
  endtask

  task automatic wait_change(input int maxc, output int n, output logic [3:0] v);
    logic [3:0] cur;
    cur = bus.LED;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.LED === cur && n < maxc);
    v = bus.LED;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pre, post, v, v1;
    int n, bad, spd, per, nup, ndn, on_cnt, frz;
    logic [7:0] pwm_prev;

    bus.KEY = 4'hF;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_led", bus.LED, 4'h0);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.LED !== 4'h0) bad++;
    end
    check("off_hold", bad, 0);

    // Glitches shorter than the debounce window must not press.
    for (int g = 0; g < 3; g++) begin
      n = $urandom_range(1, DEB - 1);
      @(posedge clk); #1 bus.KEY = 4'b1110;
      repeat (n) @(posedge clk);
      #1 bus.KEY = 4'hF;
      repeat (10) @(posedge clk);
    end
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.LED !== 4'h0) bad++;
    end
    check("glitch_rejected", bad, 0);

    // Bar mode with exact press latency.
    repeat ($urandom_range(0, 40)) @(posedge clk);
    press(4'b0001, pre, post);
    check("bar_latency_pre", pre, 4'h0);
    check("bar_latency_post", post, bar_led(0));
    for (int i = 1; i <= 8; i++) begin
      wait_change(200, n, v);
      check("bar_period", n, SD);
      check("bar_value", v, bar_led(i));
    end

    // Simultaneous KEY0 + KEY3: only the mode change takes effect.
    repeat ($urandom_range(0, 63)) @(posedge clk);
    press(4'b1001, pre, post);
    check("simul_chase_led", post, chase_led(0));
    for (int i = 1; i <= 2; i++) begin
      wait_change(200, n, v);
      check("simul_period", n, SD);
      check("simul_value", v, chase_led(i));
    end

    // Speed up / down with saturation.
    spd = 0;
    nup = $urandom_range(5, 6);
    for (int j = 0; j < nup; j++) begin
      repeat ($urandom_range(0, 20)) @(posedge clk);
      press(4'b0100, pre, post);
      spd = (spd < 3) ? spd + 1 : 3;
      per = SD >> spd;
      wait_change(300, n, v1);
      wait_change(300, n, v);
      check("speed_up_period", n, per);
      check("speed_up_step", v, {v1[2:0], v1[3]});
    end
    ndn = $urandom_range(5, 6);
    for (int j = 0; j < ndn; j++) begin
      repeat ($urandom_range(0, 20)) @(posedge clk);
      press(4'b1000, pre, post);
      spd = (spd > 0) ? spd - 1 : 0;
      per = SD >> spd;
      wait_change(300, n, v1);
      wait_change(300, n, v);
      check("speed_dn_period", n, per);
      check("speed_dn_step", v, {v1[2:0], v1[3]});
    end

    // Blink.
    press(4'b0001, pre, post);
    check("blink_on", post, 4'hF);
    wait_change(200, n, v);
    check("blink_period", n, SD);
    check("blink_off", v, 4'h0);

    // Breathe: pause 21 edges after the mode change edge.
    press(4'b0001, pre, post);
    check("breathe_start", post, 4'h0);
    repeat (13) @(posedge clk);
    #1 bus.KEY = 4'b1101;
    repeat (DEB + 3) @(posedge clk);
    @(posedge clk); #1 bus.KEY = 4'hF;
    frz = tri_lvl((21 - 1) / ((SD >> 0) >> 5));
    on_cnt = 0;
    repeat (1024) begin
      @(negedge clk);
      if (bus.LED === 4'hF) on_cnt++;
      else if (bus.LED !== 4'h0) on_cnt = on_cnt + 100000;
    end
    check("pause_duty", on_cnt, 32 * frz);

    // Resume: ramp continues from the frozen level, checked cycle by cycle.
    press(4'b0010, pre, post);
    pwm_prev = pwm_m;
    bad = 0;
    for (int k = 2; k < 122; k++) begin
      @(negedge clk);
      if (bus.LED !== ((pwm_prev[7:3] < 5'(tri_lvl(frz + (k - 1) / 2))) ? 4'hF : 4'h0)) bad++;
      pwm_prev = pwm_m;
    end
    check("resume_ramp", bad, 0);

    // Back round to chase, then reset with KEY0 held.
    press(4'b0001, pre, post);
    check("to_off", post, 4'h0);
    press(4'b0001, pre, post);
    check("to_bar", post, bar_led(0));
    press(4'b0001, pre, post);
    check("to_chase", post, chase_led(0));
    @(posedge clk); #1 bus.KEY = 4'b1110;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_led", bus.LED, 4'h0);
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.LED !== 4'h0) bad++;
    end
    check("held_key_no_press", bad, 0);
    @(posedge clk); #1 bus.KEY = 4'hF;
    press(4'b0001, pre, post);
    check("repress_pre", pre, 4'h0);
    check("repress_bar", post, bar_led(0));
    wait_change(200, n, v);
    check("repress_period", n, SD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
